// File: rtl/mux_uart_tx.sv
// MUX0 serial transmit: bus-mapped status/data registers, FIFO, 8N1 shifter.
// Define MUX_UART_PARITY_EN for 8E1 frames with an even parity bit.
module mux_uart_tx #(
    parameter logic [15:0] BASE_ADDR  = 16'hF200,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        write_en,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        hit,
    output logic        txd,
    output logic        tx_busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_MAX  = BW'(CLK_DIV - 1);
    localparam logic [15:0]   DATA_ADDR = BASE_ADDR + 16'd1;

`ifdef MUX_UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t          state, state_nx;
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic [BW-1:0]   baud;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            overrun;
    logic            baud_wrap, fifo_empty, fifo_full;
    logic            wr_data, wr_stat, push, pop, txd_nx;
`ifdef MUX_UART_PARITY_EN
    logic            par_bit;
`endif

    assign wr_data    = write_en && (address == DATA_ADDR);
    assign wr_stat    = write_en && (address == BASE_ADDR);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign baud_wrap  = (baud == BAUD_MAX);
    // A pop frees a slot in the same cycle, so a full FIFO still takes the byte.
    assign push       = wr_data && (!fifo_full || pop);

    assign hit      = (address == BASE_ADDR) || (address == DATA_ADDR);
    assign data_out = (address == BASE_ADDR)
                    ? {2'b00, overrun, 1'b0, ~tx_busy, 1'b0, ~fifo_full, 1'b0}
                    : 8'h00;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   if (!fifo_empty) state_nx = START;
            START:  if (baud_wrap) state_nx = DATA;
`ifdef MUX_UART_PARITY_EN
            DATA:   if (baud_wrap && bit_cnt == 3'd7) state_nx = PARITY;
            PARITY: if (baud_wrap) state_nx = STOP;
`else
            DATA:   if (baud_wrap && bit_cnt == 3'd7) state_nx = STOP;
`endif
            STOP:   if (baud_wrap) state_nx = fifo_empty ? IDLE : START;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        pop    = 1'b0;
        txd_nx = 1'b1;
        unique case (state)
            IDLE:   pop = !fifo_empty;
            START:  txd_nx = 1'b0;
            DATA:   txd_nx = shreg[0];
`ifdef MUX_UART_PARITY_EN
            PARITY: txd_nx = par_bit;
`endif
            STOP:   pop = baud_wrap && !fifo_empty;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (wr_stat)
                overrun <= 1'b0;
            else if (wr_data && fifo_full && !pop)
                overrun <= 1'b1;
        end
    end

    // txd and tx_busy are registered from the current state, one clock behind it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            baud    <= '0;
            bit_cnt <= 3'd0;
            shreg   <= 8'h00;
            txd     <= 1'b1;
            tx_busy <= 1'b0;
`ifdef MUX_UART_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            txd     <= txd_nx;
            tx_busy <= (state != IDLE) || !fifo_empty;
            if (state == IDLE) baud <= '0;
            else               baud <= baud_wrap ? '0 : baud + BW'(1);
            if (state != DATA)  bit_cnt <= 3'd0;
            else if (baud_wrap) bit_cnt <= bit_cnt + 3'd1;
            if (pop) begin
                shreg <= fifo_mem[rd_ptr];
`ifdef MUX_UART_PARITY_EN
                par_bit <= ^fifo_mem[rd_ptr];
`endif
            end else if (state == DATA && baud_wrap) begin
                shreg <= {1'b0, shreg[7:1]};
            end
        end
    end
endmodule

// File: tb/tb_mux_uart_tx.sv
// Directed bench for mux_uart_tx: bus writes feed a byte scoreboard,
// a serial monitor decodes txd frames and checks them against it.
module tb_mux_uart_tx;
    localparam int CLK_DIV = 4;
`ifdef MUX_UART_PARITY_EN
    localparam int NBITS = 10;
    localparam int FRAME = 44;
`else
    localparam int NBITS = 9;
    localparam int FRAME = 40;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] address = 16'h0000;
    logic        write_en = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        hit, txd, tx_busy;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic [7:0]  sb[$];
    int          starts[$];

    mux_uart_tx #(
        .BASE_ADDR(16'hF200),
        .CLK_DIV(CLK_DIV),
        .FIFO_DEPTH(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .address(address),
        .write_en(write_en),
        .data_in(data_in),
        .data_out(data_out),
        .hit(hit),
        .txd(txd),
        .tx_busy(tx_busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        address  = a;
        data_in  = d;
        write_en = 1'b1;
        @(negedge clock);
        write_en = 1'b0;
        address  = 16'h0000;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [7:0] d,
                            output logic h);
        address  = a;
        write_en = 1'b0;
        #1;
        d = data_out;
        h = hit;
    endtask

    task automatic wait_idle(input int max, output int c);
        c = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clock);
            if (tx_busy === 1'b0) begin
                c = cyc;
                break;
            end
        end
        chk("idle_reached", (c >= 0), 1'b1);
    endtask

    // Serial monitor: samples each bit in the middle of its cell.
    initial begin : monitor
        logic [9:0] bits;
        logic [7:0] exp;
        bits = '0;
        forever begin
            @(negedge clock);
            if (mon_en && !reset && txd === 1'b0) begin
                starts.push_back(cyc);
                repeat (CLK_DIV / 2) @(negedge clock);
                chk("start_bit", txd, 1'b0);
                for (int i = 0; i < NBITS; i++) begin
                    repeat (CLK_DIV) @(negedge clock);
                    bits[i] = txd;
                end
                chk("sb_nonempty", (sb.size() > 0), 1'b1);
                if (sb.size() > 0) begin
                    exp = sb.pop_front();
                    chk("rx_data", bits[7:0], exp);
`ifdef MUX_UART_PARITY_EN
                    chk("parity_bit", bits[8], ^exp);
`endif
                    chk("stop_bit", bits[NBITS-1], 1'b1);
                end
            end
        end
    end

    initial begin : stim
        logic [7:0] rd;
        logic       h;
        int         w, c, s0, lows;
        bit         fell;
        logic [7:0] burst [5];
        burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'hC3;
        burst[3] = 8'h5A; burst[4] = 8'hFF;

        // reset state
        repeat (3) @(negedge clock);
        chk("rst_txd", txd, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        reset = 1'b0;
        bus_read(16'hF200, rd, h);
        chk("rst_status", rd, 8'h0A);
        chk("hit_f200", h, 1'b1);
        bus_read(16'hF201, rd, h);
        chk("read_f201", rd, 8'h00);
        chk("hit_f201", h, 1'b1);
        bus_read(16'hF202, rd, h);
        chk("hit_f202", h, 1'b0);
        chk("read_f202", rd, 8'h00);
        @(negedge clock);
        mon_en = 1'b1;

        // single byte: latency, frame length, busy drop
        starts.delete();
        sb.push_back(8'h48);
        bus_write(16'hF201, 8'h48);
        w = cyc;
        @(negedge clock);
        chk("busy_after_write", tx_busy, 1'b1);
        wait_idle(200, c);
        s0 = (starts.size() > 0) ? starts[0] : -1000;
        chk("txd_latency", s0 - w, 2);
        chk("busy_drop_delay", c - s0, FRAME);
        bus_read(16'hF200, rd, h);
        chk("status_idle", rd, 8'h0A);

        // burst of five fills the FIFO, sixth overruns
        repeat (3) @(negedge clock);
        starts.delete();
        for (int i = 0; i < 5; i++) begin
            sb.push_back(burst[i]);
            bus_write(16'hF201, burst[i]);
        end
        bus_read(16'hF200, rd, h);
        chk("status_full", rd, 8'h00);
        bus_write(16'hF201, 8'hEE);
        bus_read(16'hF200, rd, h);
        chk("status_overrun", rd, 8'h20);
        bus_write(16'hF200, 8'h5C);
        bus_read(16'hF200, rd, h);
        chk("overrun_cleared", rd, 8'h00);

        // back-to-back frames with no idle gap
        wait_idle(400, c);
        chk("burst_frames", starts.size(), 5);
        if (starts.size() == 5) begin
            for (int i = 1; i < 5; i++)
                chk("frame_spacing", starts[i] - starts[i-1], FRAME);
            chk("burst_total", c - starts[0], 5 * FRAME);
        end
        chk("sb_drained", sb.size(), 0);

        // reset in the middle of bit 3
        mon_en = 1'b0;
        @(negedge clock);
        bus_write(16'hF201, 8'hA5);
        fell = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (txd === 1'b0) begin
                fell = 1'b1;
                break;
            end
        end
        chk("abort_start_seen", fell, 1'b1);
        repeat (17) @(negedge clock);
        chk("bit3_low", txd, 1'b0);
        reset = 1'b1;
        #1;
        chk("async_txd", txd, 1'b1);
        chk("async_busy", tx_busy, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        bus_read(16'hF200, rd, h);
        chk("status_after_abort", rd, 8'h0A);
        lows = 0;
        repeat (60) begin
            @(negedge clock);
            if (txd !== 1'b1) lows++;
        end
        chk("no_tail_bits", lows, 0);
        mon_en = 1'b1;

        // 0x07: odd popcount, parity bit 1 when enabled
        starts.delete();
        sb.push_back(8'h07);
        bus_write(16'hF201, 8'h07);
        @(negedge clock);
        wait_idle(200, c);
        s0 = (starts.size() > 0) ? starts[0] : -1000;
        chk("frame_len_07", c - s0, FRAME);
        chk("sb_final", sb.size(), 0);

        repeat (5) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
